// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg: shared constants, FSM encoding and IEEE-754 single word layout. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fp_pkg;
  localparam int         EXP_W      = 8;
  localparam int         FRAC_W     = 23;
  localparam int         MANT_RAW_W = 27;
  localparam logic [7:0] EXP_MAX    = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } norm_state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;
endpackage

`default_nettype wire

// File: rtl/fp_round_rne.sv
// ---------------------------------------------------------------------------
// fp_round_rne: round-to-nearest-even increment, exponent adjust, overflow. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fp_round_rne #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic [FRAC_W:0]   i_mant,
  input  logic              i_guard,
  input  logic              i_round,
  input  logic              i_sticky,
  input  logic [EXP_W:0]    i_exp,
  output logic [EXP_W-1:0]  o_exp,
  output logic [FRAC_W-1:0] o_frac,
  output logic              o_overflow,
  output logic              o_inexact
);
  import fp_pkg::*;

  logic              w_inc;
  logic [FRAC_W+1:0] w_sum;
  logic [EXP_W:0]    w_exp_adj;
  logic [FRAC_W-1:0] w_frac;

  assign w_inc = i_guard & (i_round | i_sticky | i_mant[0]);
  assign w_sum = {1'b0, i_mant} + {{(FRAC_W+1){1'b0}}, w_inc};

  // Carry-out renormalizes to 1.0; a subnormal rounding into the hidden bit becomes the smallest normal.
  always_comb begin
    w_exp_adj = i_exp;
    w_frac    = w_sum[FRAC_W-1:0];
    if (w_sum[FRAC_W+1]) begin
      w_exp_adj = i_exp + 1'b1;
      w_frac    = '0;
    end else if (i_exp == '0 && w_sum[FRAC_W]) begin
      w_exp_adj = {{EXP_W{1'b0}}, 1'b1};
    end
  end

  assign o_overflow = (w_exp_adj >= {1'b0, EXP_MAX});
  assign o_exp      = o_overflow ? EXP_MAX : w_exp_adj[EXP_W-1:0];
  assign o_frac     = o_overflow ? '0 : w_frac;
  assign o_inexact  = i_guard | i_round | i_sticky | o_overflow;
endmodule

`default_nettype wire

// File: rtl/fp_norm_round.sv
// ---------------------------------------------------------------------------
// fp_norm_round: iterative normalize (one bit/cycle) and RNE round after fpa. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fp_norm_round #(
  parameter int EXP_W  = fp_pkg::EXP_W,
  parameter int FRAC_W = fp_pkg::FRAC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W-1:0]        in_exp,
  input  logic [FRAC_W+3:0]       in_mant,
  input  logic                    in_sticky,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   out_result,
  output logic                    out_overflow,
  output logic                    out_inexact
);
  import fp_pkg::*;

  norm_state_t       r_state,    w_state_nxt;
  logic              r_sign,     w_sign_nxt;
  logic [EXP_W:0]    r_exp,      w_exp_nxt;
  logic [FRAC_W+3:0] r_mant,     w_mant_nxt;
  logic              r_sticky,   w_sticky_nxt;
  fp32_t             r_result,   w_result_nxt;
  logic              r_overflow, w_overflow_nxt;
  logic              r_inexact,  w_inexact_nxt;

  logic [EXP_W-1:0]  w_rnd_exp;
  logic [FRAC_W-1:0] w_rnd_frac;
  logic              w_rnd_ovf;
  logic              w_rnd_inx;

  fp_round_rne #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W)
  ) u_round (
    .i_mant     (r_mant[FRAC_W+2:2]),
    .i_guard    (r_mant[1]),
    .i_round    (r_mant[0]),
    .i_sticky   (r_sticky),
    .i_exp      (r_exp),
    .o_exp      (w_rnd_exp),
    .o_frac     (w_rnd_frac),
    .o_overflow (w_rnd_ovf),
    .o_inexact  (w_rnd_inx)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_sign_nxt     = r_sign;
    w_exp_nxt      = r_exp;
    w_mant_nxt     = r_mant;
    w_sticky_nxt   = r_sticky;
    w_result_nxt   = r_result;
    w_overflow_nxt = r_overflow;
    w_inexact_nxt  = r_inexact;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_sign_nxt   = in_sign;
          w_exp_nxt    = {1'b0, in_exp};
          w_mant_nxt   = in_mant;
          w_sticky_nxt = in_sticky;
          w_state_nxt  = ST_NORM;
        end
      end
      ST_NORM: begin
        if (r_exp == {1'b0, EXP_MAX}) begin
          w_result_nxt   = '{sign: r_sign, exp: EXP_MAX, frac: r_mant[FRAC_W+1:2]};
          w_overflow_nxt = 1'b0;
          w_inexact_nxt  = 1'b0;
          w_state_nxt    = ST_DONE;
        end else if (r_mant[FRAC_W+3]) begin
          w_mant_nxt   = {1'b0, r_mant[FRAC_W+3:1]};
          w_sticky_nxt = r_sticky | r_mant[0];
          w_exp_nxt    = r_exp + 1'b1;
          w_state_nxt  = ST_ROUND;
        end else if (r_mant[FRAC_W+2]) begin
          w_state_nxt = ST_ROUND;
        end else if (r_mant == '0 || r_exp <= {{EXP_W{1'b0}}, 1'b1}) begin
          // Zero or subnormal: stop shifting, the exponent floor is reached.
          w_exp_nxt   = '0;
          w_state_nxt = ST_ROUND;
        end else begin
          w_mant_nxt = {r_mant[FRAC_W+2:0], 1'b0};
          w_exp_nxt  = r_exp - 1'b1;
        end
      end
      ST_ROUND: begin
        w_result_nxt   = '{sign: r_sign, exp: w_rnd_exp, frac: w_rnd_frac};
        w_overflow_nxt = w_rnd_ovf;
        w_inexact_nxt  = w_rnd_inx;
        w_state_nxt    = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sign     <= 1'b0;
      r_exp      <= '0;
      r_mant     <= '0;
      r_sticky   <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_inexact  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sign     <= w_sign_nxt;
      r_exp      <= w_exp_nxt;
      r_mant     <= w_mant_nxt;
      r_sticky   <= w_sticky_nxt;
      r_result   <= w_result_nxt;
      r_overflow <= w_overflow_nxt;
      r_inexact  <= w_inexact_nxt;
    end
  end

  assign in_ready     = (r_state == ST_IDLE);
  assign out_valid    = (r_state == ST_DONE);
  assign out_result   = r_result;
  assign out_overflow = r_overflow;
  assign out_inexact  = r_inexact;
endmodule

`default_nettype wire
